// File: rtl/seq_word_scanner.sv
// seq_word_scanner: shifts W-bit words MSB-first through a non-overlapping PAT_LEN-bit detector, reporting match count and first-match index over valid/ready
module seq_word_scanner #(
  parameter int W = 8,
  parameter int PAT_LEN = 4,
  parameter int CNT_W = 4,
  parameter int IDX_W = 3,
  parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1101
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_carry,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count,
  output logic [IDX_W-1:0]   out_first,
  output logic               det_pulse,
  output logic [1:0]         state_out
);
  localparam int HC_W = $clog2(PAT_LEN);
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, REPORT = 2'b10} state_t;
  state_t state, state_next;
  logic [W-1:0] word;
  logic [IDX_W-1:0] idx, first;
  logic [CNT_W-1:0] count;
  logic [PAT_LEN-2:0] hist;
  logic [HC_W-1:0] hist_cnt;
  logic [PAT_LEN-1:0] pattern, window;
  logic carry, match, idle, shifting, keep_hist;
  assign idle = state == IDLE;
  assign shifting = state == SHIFT;
  assign window = {hist, word[W-1]};
  assign match = hist_cnt == HC_W'(PAT_LEN - 1) && window == pattern;
  assign keep_hist = cfg_we ? cfg_carry : carry;
  assign in_ready = idle;
  assign out_valid = state == REPORT;
  assign out_count = count;
  assign out_first = first;
  assign state_out = state;
  always_comb begin
    state_next = idle ? (in_valid ? SHIFT : IDLE)
               : shifting ? (idx == IDX_W'(W - 1) ? REPORT : SHIFT)
               : state == REPORT ? (out_ready ? IDLE : REPORT)
               : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= PAT_RST;
      carry <= 1'b0;
      word <= '0;
      idx <= '0;
      count <= '0;
      first <= '0;
      hist <= '0;
      hist_cnt <= '0;
      det_pulse <= 1'b0;
    end else begin
      det_pulse <= shifting && match;
      if (idle) begin
        if (cfg_we) begin
          pattern <= cfg_pattern;
          carry <= cfg_carry;
        end
        if (in_valid) begin
          word <= in_data;
          idx <= '0;
          count <= '0;
          first <= '0;
          if (!keep_hist) begin
            hist <= '0;
            hist_cnt <= '0;
          end
        end
      end else if (shifting) begin
        word <= word << 1;
        idx <= idx + 1'b1;
        hist <= window[PAT_LEN-2:0];
        // a match restarts the fill count so the next match needs PAT_LEN fresh bits
        hist_cnt <= match ? '0 : hist_cnt == HC_W'(PAT_LEN - 1) ? hist_cnt : hist_cnt + 1'b1;
        if (match) begin
          count <= &count ? count : count + 1'b1;
          if (count == '0) first <= idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_word_scanner.sv
// tb_seq_word_scanner: directed scoreboard bench for seq_word_scanner
module tb_seq_word_scanner;
  localparam int W = 8, PAT_LEN = 4, CNT_W = 4, IDX_W = 3;
  logic clk = 0, reset = 1, cfg_we = 0, cfg_carry = 0, in_valid = 0, out_ready = 0;
  logic [PAT_LEN-1:0] cfg_pattern = '0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, det_pulse;
  logic [CNT_W-1:0] out_count;
  logic [IDX_W-1:0] out_first;
  logic [1:0] state_out;
  int tests = 0, fails = 0, cyc = 0, t0 = 0, pulses = 0, pbase = 0;
  logic [CNT_W+IDX_W-1:0] sb[$];
  seq_word_scanner #(.W(W), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_carry(cfg_carry),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_first(out_first), .det_pulse(det_pulse),
    .state_out(state_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (det_pulse) pulses <= pulses + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [W-1:0] d, input logic we, input logic [PAT_LEN-1:0] p,
                      input logic c, input bit push, input int ec, input int ef);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", in_ready, 1);
    cfg_we = we;
    cfg_pattern = p;
    cfg_carry = c;
    in_valid = 1;
    in_data = d;
    t0 = cyc + 1;
    pbase = pulses;
    if (push) sb.push_back({ec[CNT_W-1:0], ef[IDX_W-1:0]});
    @(negedge clk);
    in_valid = 0;
    cfg_we = 0;
    check("state_shift", state_out, 2'b01);
    check("in_ready_low", in_ready, 0);
  endtask
  task automatic get(input int hold, input int epulse);
    int n = 0;
    logic [CNT_W+IDX_W-1:0] e = '0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", out_valid, 1);
    check("latency", cyc - t0, W);
    check("sb_size", sb.size(), 1);
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_count", out_count, e[CNT_W+IDX_W-1:IDX_W]);
      check("hold_first", out_first, e[IDX_W-1:0]);
      @(negedge clk);
    end
    out_ready = 1;
    check("out_count", out_count, e[CNT_W+IDX_W-1:IDX_W]);
    check("out_first", out_first, e[IDX_W-1:0]);
    @(negedge clk);
    out_ready = 0;
    check("valid_drop", out_valid, 0);
    check("state_idle", state_out, 2'b00);
    check("det_pulses", pulses - pbase, epulse);
  endtask
  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_state", state_out, 2'b00);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_first", out_first, 0);
    check("rst_det", det_pulse, 0);
    reset = 0;
    send(8'b1101_1101, 0, 4'b0000, 0, 1, 2, 3);
    get(0, 2);
    send(8'b1101_1010, 0, 4'b0000, 0, 1, 1, 3);
    get(0, 1);
    send(8'b0000_0110, 1, 4'b1101, 1, 1, 0, 0);
    get(0, 0);
    send(8'b1000_0000, 0, 4'b0000, 0, 1, 1, 0);
    get(0, 1);
    send(8'b0000_0110, 1, 4'b1101, 0, 1, 0, 0);
    get(0, 0);
    send(8'b1000_0000, 0, 4'b0000, 0, 1, 0, 0);
    get(0, 0);
    send(8'b1101_1101, 0, 4'b0000, 0, 1, 2, 3);
    get(5, 2);
    send(8'b0110_0110, 0, 4'b0000, 0, 1, 0, 0);
    get(0, 0);
    send(8'b1101_1101, 0, 4'b0000, 0, 1, 2, 3);
    cfg_we = 1;
    cfg_pattern = 4'b0110;
    repeat (2) @(negedge clk);
    cfg_we = 0;
    get(0, 2);
    cfg_we = 1;
    cfg_pattern = 4'b0110;
    cfg_carry = 0;
    @(negedge clk);
    cfg_we = 0;
    send(8'b0110_0110, 0, 4'b0000, 0, 1, 2, 3);
    get(0, 2);
    send(8'b0110_0110, 0, 4'b0000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("pre_reset_shift", state_out, 2'b01);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_state", state_out, 2'b00);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    seen = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_result", seen, 0);
    send(8'b1101_1101, 0, 4'b0000, 0, 1, 2, 3);
    get(0, 2);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
